// File: rtl/vliw_regfile_pkg.sv
// Shared sizing, types and address helpers for the VLIW register file slice.
package vliw_pkg;

  function automatic int addr_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // An address is "live" when it maps to real storage that honours writes/locks.
  function automatic bit addr_live(int a, int nregs, bit zero_reg);
    return (a < nregs) && !(zero_reg && (a == 0));
  endfunction

  localparam int          REG_W         = 16;
  localparam int          NUM_REGS      = 16;
  localparam int          NUM_SLOTS     = 2;
  localparam int          NUM_RD        = 4;
  localparam logic [15:0] REG_RESET_VAL = 16'h00FF;
  localparam int          REG_AW        = addr_width(NUM_REGS);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]  reg_data_t;

endpackage

// File: rtl/vliw_regfile_scoreboard.sv
// Per-register pending bits: lock/clear priority, lock_err pulse and read readiness.
module regfile_scoreboard
  import vliw_pkg::*;
#(
  parameter int NREGS    = NUM_REGS,
  parameter int NRD      = NUM_RD,
  parameter int NWR      = NUM_SLOTS,
  parameter bit ZERO_REG = 1'b0,
  parameter int AW       = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREGS-1:0]  wr_hit,
  input  logic [NWR-1:0]    lock_en,
  input  logic [NWR*AW-1:0] lock_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_ready,
  output logic              lock_err
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic [NREGS-1:0] lock_set;
  logic             err_d;
  logic             lock_err_q;

  // A lock wins over a same-cycle write: a new producer has been issued.
  always_comb begin
    lock_set = '0;
    err_d    = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (lock_en[j] && addr_live(int'(lock_addr[j*AW +: AW]), NREGS, ZERO_REG)) begin
        if (lock_set[lock_addr[j*AW +: AW]]) err_d = 1'b1;
        lock_set[lock_addr[j*AW +: AW]] = 1'b1;
      end
    end
    if (|(lock_set & pending_q & ~wr_hit)) err_d = 1'b1;
    pending_d = lock_set | (pending_q & ~wr_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      lock_err_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      lock_err_q <= err_d;
    end
  end

  always_comb begin
    rd_ready = '1;
    for (int i = 0; i < NRD; i++) begin
      if (addr_live(int'(rd_addr[i*AW +: AW]), NREGS, ZERO_REG) &&
          pending_q[rd_addr[i*AW +: AW]] && !wr_hit[rd_addr[i*AW +: AW]])
        rd_ready[i] = 1'b0;
    end
  end

  assign lock_err = lock_err_q;

endmodule

// File: rtl/vliw_regfile.sv
// Multi-ported architectural register file with write-to-read bypass and pending scoreboard.
module vliw_regfile
  import vliw_pkg::*;
#(
  parameter int               WIDTH     = REG_W,
  parameter int               NREGS     = NUM_REGS,
  parameter int               NRD       = NUM_RD,
  parameter int               NWR       = NUM_SLOTS,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(REG_RESET_VAL),
  parameter bit               ZERO_REG  = 1'b0,
  localparam int              AW        = addr_width(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_ready,
  input  logic [NWR-1:0]       lock_en,
  input  logic [NWR*AW-1:0]    lock_addr,
  output logic                 wr_conflict,
  output logic                 lock_err
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] wd [NREGS];
  logic [NREGS-1:0] we;
  logic             conflict_d;
  logic             wr_conflict_q;

  // Per-register write decode; later slots overwrite earlier ones so the highest slot wins.
  always_comb begin
    we         = '0;
    conflict_d = 1'b0;
    for (int r = 0; r < NREGS; r++) wd[r] = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && addr_live(int'(wr_addr[j*AW +: AW]), NREGS, ZERO_REG)) begin
        if (we[wr_addr[j*AW +: AW]]) conflict_d = 1'b1;
        we[wr_addr[j*AW +: AW]] = 1'b1;
        wd[wr_addr[j*AW +: AW]] = wr_data[j*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    localparam logic [WIDTH-1:0] INIT_VAL = (ZERO_REG && gi == 0) ? '0 : RESET_VAL;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      mem_q[gi] <= INIT_VAL;
      else if (we[gi]) mem_q[gi] <= wd[gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_conflict_q <= 1'b0;
    else        wr_conflict_q <= conflict_d;
  end

  // Bypass is suppressed while reset is held so reads show the reset contents.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (addr_live(int'(rd_addr[i*AW +: AW]), NREGS, ZERO_REG)) begin
        if (rst_n && we[rd_addr[i*AW +: AW]])
          rd_data[i*WIDTH +: WIDTH] = wd[rd_addr[i*AW +: AW]];
        else
          rd_data[i*WIDTH +: WIDTH] = mem_q[rd_addr[i*AW +: AW]];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .NRD     (NRD),
    .NWR     (NWR),
    .ZERO_REG(ZERO_REG),
    .AW      (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_hit   (we),
    .lock_en  (lock_en),
    .lock_addr(lock_addr),
    .rd_addr  (rd_addr),
    .rd_ready (rd_ready),
    .lock_err (lock_err)
  );

  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_vliw_regfile.sv
// Scoreboard bench for vliw_regfile: default instance plus a ZERO_REG=1 instance on shared inputs.
module tb_vliw_regfile;
  localparam int W   = 16;
  localparam int AW  = 4;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int K_DATA = 0;
  localparam int K_RDY  = 1;
  localparam int K_CONF = 2;
  localparam int K_LERR = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NWR-1:0]    wr_en, lock_en;
  logic [NWR*AW-1:0] wr_addr, lock_addr;
  logic [NWR*W-1:0]  wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*W-1:0]  rd_data_a, rd_data_z;
  logic [NRD-1:0]    rd_ready_a, rd_ready_z;
  logic              wr_conflict_a, wr_conflict_z, lock_err_a, lock_err_z;

  always #5 clk = ~clk;

  vliw_regfile dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_ready(rd_ready_a),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .wr_conflict(wr_conflict_a), .lock_err(lock_err_a)
  );

  vliw_regfile #(.ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_ready(rd_ready_z),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .wr_conflict(wr_conflict_z), .lock_err(lock_err_z)
  );

  typedef struct {
    string       name;
    bit          zdut;
    int          kind;
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [15:0] observe(bit z, int kind, int idx);
    case (kind)
      K_DATA:  return z ? rd_data_z[idx*W +: W] : rd_data_a[idx*W +: W];
      K_RDY:   return {12'd0, (z ? rd_ready_z : rd_ready_a)};
      K_CONF:  return {15'd0, (z ? wr_conflict_z : wr_conflict_a)};
      default: return {15'd0, (z ? lock_err_z : lock_err_a)};
    endcase
  endfunction

  // Monitor: every falling edge, drain and compare what the driver queued this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++;
      if (observe(e.zdut, e.kind, e.idx) !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: got %h, want %h", e.name, observe(e.zdut, e.kind, e.idx), e.val);
      end else begin
        $display("[TB] ok   %s = %h", e.name, e.val);
      end
    end
  end

  task automatic push_exp(string name, bit z, int kind, int idx, logic [15:0] v);
    exp_t x;
    x.name = name; x.zdut = z; x.kind = kind; x.idx = idx; x.val = v;
    sb_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    lock_en = '0; lock_addr = '0;
  endtask

  task automatic set_wr(int j, int a, logic [15:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*W +: W] = d;
  endtask

  task automatic set_lock(int j, int a);
    lock_en[j] = 1'b1;
    lock_addr[j*AW +: AW] = AW'(a);
  endtask

  task automatic set_rd(int a0, int a1, int a2, int a3);
    rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    set_rd(0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Build some state for reset to wipe: r1 written, r6 locked.
    tick(); set_wr(0, 1, 16'hBEEF); set_lock(0, 6); set_rd(1, 6, 0, 0);
    push_exp("pre_byp_r1", 0, K_DATA, 0, 16'hBEEF);
    push_exp("pre_rdy", 0, K_RDY, 0, 16'h000F);
    tick(); clr();
    push_exp("pre_store_r1", 0, K_DATA, 0, 16'hBEEF);
    push_exp("pre_rdy_r6_pend", 0, K_RDY, 0, 16'h000D);

    // Asynchronous reset mid-cycle with both write slots active.
    tick(); set_wr(0, 1, 16'h1111); set_wr(1, 2, 16'h2222); set_rd(1, 2, 3, 6);
    #2 rst_n = 1'b0;
    for (int i = 0; i < NRD; i++) push_exp($sformatf("rst_rd%0d", i), 0, K_DATA, i, 16'h00FF);
    push_exp("rst_rdy", 0, K_RDY, 0, 16'h000F);
    push_exp("rst_conf", 0, K_CONF, 0, 16'h0000);
    push_exp("rst_lerr", 0, K_LERR, 0, 16'h0000);
    tick(); rst_n = 1'b1; clr();
    push_exp("post_rst_r1", 0, K_DATA, 0, 16'h00FF);
    push_exp("post_rst_r2", 0, K_DATA, 1, 16'h00FF);
    push_exp("post_rst_rdy", 0, K_RDY, 0, 16'h000F);

    // Write with same-cycle bypass, then from storage.
    tick(); set_wr(0, 3, 16'h1234); set_rd(3, 4, 0, 0);
    push_exp("byp_r3", 0, K_DATA, 0, 16'h1234);
    push_exp("r4_untouched", 0, K_DATA, 1, 16'h00FF);
    tick(); clr();
    push_exp("store_r3", 0, K_DATA, 0, 16'h1234);
    push_exp("r4_still", 0, K_DATA, 1, 16'h00FF);

    // Two slots on r5: highest slot wins, conflict pulses once.
    tick(); set_wr(0, 5, 16'hAAAA); set_wr(1, 5, 16'h5555); set_rd(5, 0, 0, 0);
    push_exp("conf_byp_r5", 0, K_DATA, 0, 16'h5555);
    push_exp("conf_pre", 0, K_CONF, 0, 16'h0000);
    tick(); clr();
    push_exp("conf_store_r5", 0, K_DATA, 0, 16'h5555);
    push_exp("conf_pulse", 0, K_CONF, 0, 16'h0001);
    tick();
    push_exp("conf_done", 0, K_CONF, 0, 16'h0000);

    // Scoreboard: lock r7, write it back in cycle 3.
    tick(); set_lock(0, 7); set_rd(7, 0, 0, 0);
    push_exp("sb_c0_rdy", 0, K_RDY, 0, 16'h000F);
    tick(); clr();
    push_exp("sb_c1_rdy", 0, K_RDY, 0, 16'h000E);
    tick();
    push_exp("sb_c2_rdy", 0, K_RDY, 0, 16'h000E);
    tick(); set_wr(1, 7, 16'h0042);
    push_exp("sb_c3_rdy", 0, K_RDY, 0, 16'h000F);
    push_exp("sb_c3_data", 0, K_DATA, 0, 16'h0042);
    tick(); clr();
    push_exp("sb_c4_rdy", 0, K_RDY, 0, 16'h000F);
    push_exp("sb_c4_data", 0, K_DATA, 0, 16'h0042);
    // Lock and write r7 together: stays pending.
    tick(); set_lock(1, 7); set_wr(0, 7, 16'h0099);
    push_exp("lw_same_rdy", 0, K_RDY, 0, 16'h000F);
    push_exp("lw_same_data", 0, K_DATA, 0, 16'h0099);
    tick(); clr();
    push_exp("lw_next_rdy", 0, K_RDY, 0, 16'h000E);
    push_exp("lw_next_data", 0, K_DATA, 0, 16'h0099);
    push_exp("lw_no_lerr", 0, K_LERR, 0, 16'h0000);
    tick(); set_wr(0, 7, 16'h0001);
    tick(); clr();

    // Relocking an already-pending r2 raises lock_err once.
    tick(); set_lock(0, 2); set_rd(2, 0, 0, 0);
    push_exp("le_c0_rdy", 0, K_RDY, 0, 16'h000F);
    tick(); clr();
    push_exp("le_c1_rdy", 0, K_RDY, 0, 16'h000E);
    tick();
    push_exp("le_c2_lerr", 0, K_LERR, 0, 16'h0000);
    tick(); set_lock(1, 2);
    push_exp("le_c3_rdy", 0, K_RDY, 0, 16'h000E);
    push_exp("le_c3_lerr", 0, K_LERR, 0, 16'h0000);
    tick(); clr();
    push_exp("le_pulse", 0, K_LERR, 0, 16'h0001);
    push_exp("le_still_pend", 0, K_RDY, 0, 16'h000E);
    tick();
    push_exp("le_done", 0, K_LERR, 0, 16'h0000);
    push_exp("le_pend_hold", 0, K_RDY, 0, 16'h000E);
    tick(); set_wr(0, 2, 16'h0000);
    tick(); clr();
    push_exp("le_cleared", 0, K_RDY, 0, 16'h000F);

    // Both lock slots on r9 in one cycle.
    tick(); set_lock(0, 9); set_lock(1, 9);
    tick(); clr();
    push_exp("dup_lock_lerr", 0, K_LERR, 0, 16'h0001);
    tick(); set_wr(0, 9, 16'h0000);
    push_exp("dup_lock_done", 0, K_LERR, 0, 16'h0000);
    tick(); clr();

    // r0 write+lock from both slots: ignored on the ZERO_REG instance only.
    tick(); set_wr(0, 0, 16'hFFFF); set_wr(1, 0, 16'hFFFF);
    set_lock(0, 0); set_lock(1, 0); set_rd(0, 0, 0, 0);
    push_exp("z_same_data", 1, K_DATA, 0, 16'h0000);
    push_exp("z_same_rdy", 1, K_RDY, 0, 16'h000F);
    push_exp("nz_same_byp", 0, K_DATA, 0, 16'hFFFF);
    tick(); clr();
    push_exp("z_next_data", 1, K_DATA, 0, 16'h0000);
    push_exp("z_next_rdy", 1, K_RDY, 0, 16'h000F);
    push_exp("z_no_conf", 1, K_CONF, 0, 16'h0000);
    push_exp("z_no_lerr", 1, K_LERR, 0, 16'h0000);
    push_exp("nz_store_r0", 0, K_DATA, 0, 16'hFFFF);
    push_exp("nz_conf", 0, K_CONF, 0, 16'h0001);
    push_exp("nz_lerr", 0, K_LERR, 0, 16'h0001);
    push_exp("nz_r0_pend", 0, K_RDY, 0, 16'h0000);
    tick();
    push_exp("z_lerr_quiet", 1, K_LERR, 0, 16'h0000);

    tick(); tick();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vliw_regfile.md
Name: vliw_regfile

Overview:
- Parametrised multi-ported architectural register file for the VLIW core.
- Supports one write port per issue slot and several combinational read ports, with write-to-read bypass.
- Includes a per-register pending scoreboard so operand-fetch logic can stall on registers whose in-flight results have not yet been written back.
- Sits between decode/issue (read and lock ports) and write-back (write ports); replaces the single 16-bit enabled register.

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 16, number of registers. Address width AW = $clog2(NREGS), minimum 1.
- NRD, 4, number of read ports.
- NWR, 2, number of write ports. Also the number of lock ports.
- RESET_VAL, 16'h00FF, reset value of every register, truncated or zero-extended to WIDTH.
- ZERO_REG, 0, if 1 then r0 always reads 0, and writes and locks to r0 are ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  NWR  per-slot write enable.
- wr_addr  in  NWR*AW  per-slot write address; slot j occupies bits [j*AW +: AW].
- wr_data  in  NWR*WIDTH  per-slot write data.
- rd_addr  in  NRD*AW  per-port read address.
- rd_data  out  NRD*WIDTH  per-port read data, combinational.
- rd_ready  out  NRD  per-port flag: operand is valid (not pending), combinational.
- lock_en  in  NWR  per-slot request to mark the destination register pending.
- lock_addr  in  NWR*AW  per-slot lock address.
- wr_conflict  out  1  registered 1-cycle pulse: two or more enabled writes targeted the same register in the previous cycle.
- lock_err  out  1  registered 1-cycle pulse: a lock targeted an already-pending register in the previous cycle.

Behaviour:
- Reset:
  - rst_n low asynchronously sets every register to RESET_VAL (r0 to 0 when ZERO_REG=1).
  - Clears all pending bits, wr_conflict and lock_err.
  - rd_data reflects reset contents immediately; rd_ready is 1 on all ports.
- Write:
  - Commits at posedge when wr_en[j]=1; write-to-storage latency is 1 cycle.
  - If several slots write the same address in one cycle, the highest slot index wins and wr_conflict=1 in the next cycle.
  - Writes to addresses >= NREGS are ignored.
- Read:
  - Zero latency. rd_data[i] = storage[rd_addr[i]], except as below.
  - Bypass: if any wr_en[j] with wr_addr[j]==rd_addr[i] this cycle, rd_data[i] = wr_data of the highest such j.
  - Address >= NREGS reads 0. r0 reads 0 when ZERO_REG=1, with no bypass.
- Scoreboard (pending[NREGS], registered):
  - At posedge, pending[a] is set for each lock_en[j] with lock_addr[j]=a.
  - pending[a] is cleared for each written address a that is not locked in the same cycle.
  - Lock and write to the same register in the same cycle leave pending=1, because a new producer has been issued.
  - Locking an already-pending register (pending_q=1 and not cleared this cycle) still leaves it pending, and lock_err=1 in the next cycle.
  - Two lock slots on the same register in one cycle also raise lock_err.
  - Locks to r0 (ZERO_REG=1) and to addresses >= NREGS are ignored.
- rd_ready:
  - rd_ready[i] = ~pending_q[rd_addr[i]] | (write hit on rd_addr[i] this cycle).
  - Same-cycle locks do not affect rd_ready until the next cycle.
  - Out-of-range addresses and r0 (ZERO_REG=1) always give ready=1.
- Reset mid-operation: in-flight writes and locks on that edge are discarded; the state is exactly the reset state.
- Width rules: no arithmetic on data. AW is derived from NREGS. RESET_VAL is sized to WIDTH.

Decomposition:
- Shared package vliw_pkg holds:
  - REG_W (16), NUM_REGS (16), NUM_SLOTS (2), NUM_RD (4), REG_RESET_VAL (16'h00FF);
  - typedef reg_addr_t (AW bits) and reg_data_t (WIDTH bits).
- One natural sub-module, regfile_scoreboard: the pending bits, lock/clear priority, lock_err and rd_ready generation.
- Storage, write arbitration, bypass and wr_conflict stay in vliw_regfile.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with wr_en=2'b11 active -> all 4 ports read 16'h00FF immediately, rd_ready=4'hF; after release, no write from the reset edge has committed.
- Write/bypass: slot0 writes r3=16'h1234, with rd_addr[0]=3 in the same cycle -> rd_data[0]=16'h1234 in that cycle and from storage in the next cycle; r4 still reads 16'h00FF.
- Conflict: slot0 writes r5=16'hAAAA and slot1 writes r5=16'h5555 -> same-cycle bypass gives 16'h5555; storage holds 16'h5555; wr_conflict=1 for exactly one cycle.
- Scoreboard:
  - Lock r7 in cycle 0 -> rd_ready for r7 is 0 from cycle 1.
  - Slot1 writes r7=16'h0042 in cycle 3 -> rd_ready=1 and rd_data=16'h0042 in cycle 3.
  - Lock and write of r7 in the same cycle -> r7 stays not-ready.
- lock_err: lock r2, then lock r2 again 2 cycles later without a write -> lock_err pulses once; r2 stays pending.
- ZERO_REG=1: write r0=16'hFFFF and lock r0 -> r0 reads 0, ready=1, no lock_err and no wr_conflict.
